// File: rtl/wmem_pkg.sv
// Shared constants, width helper and weight type
// for the hidden-layer weight memory.
package wmem_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_N_IN     = 8;
  localparam int DEF_N_HIDDEN = 4;

  typedef logic signed [DEF_DATA_W-1:0] weight_t;

  function automatic int addr_w(input int x);
    return (x > 1) ? $clog2(x) : 1;
  endfunction

endpackage

// File: rtl/hidden_wmem_sdp_ram.sv
// Simple dual-port RAM, sync write, registered read.
// WMEM_CLEAR_ON_RESET_EN: register array cleared on reset.
module sdp_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic signed [DATA_W-1:0] wdata,
  input  logic                     rd_ok,
  input  logic [ADDR_W-1:0]        raddr,
  output logic signed [DATA_W-1:0] rdata
);

  logic signed [DATA_W-1:0] mem [DEPTH];

`ifdef WMEM_CLEAR_ON_RESET_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end
`endif

  // Old contents win on a same-edge collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else begin
      rdata <= rd_ok ? mem[raddr] : '0;
    end
  end

endmodule

// File: rtl/hidden_wmem.sv
// Hidden-layer weight memory: (h,i) write pipeline, flat read.
// WMEM_CLEAR_ON_RESET_EN: array contents cleared on reset.
module hidden_wmem
  import wmem_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int N_IN     = DEF_N_IN,
  parameter int N_HIDDEN = DEF_N_HIDDEN,
  localparam int WMEM_SIZE = N_HIDDEN * N_IN,
  localparam int ADDR_H_W  = addr_w(N_HIDDEN),
  localparam int ADDR_I_W  = addr_w(N_IN),
  localparam int RADDR_W   = addr_w(WMEM_SIZE)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     w_wr_en,
  input  logic [ADDR_H_W-1:0]      w_addr_h,
  input  logic [ADDR_I_W-1:0]      w_addr_i,
  input  logic signed [DATA_W-1:0] w_data,
  input  logic [RADDR_W-1:0]       raddr,
  output logic signed [DATA_W-1:0] rdata
);

  logic                     h_ok;
  logic                     i_ok;
  logic                     r_ok;
  logic [RADDR_W-1:0]       w_flat;
  logic                     wp_en;
  logic [RADDR_W-1:0]       wp_addr;
  logic signed [DATA_W-1:0] wp_data;

  // Range checks collapse to 1 when the index fills its field.
  if ((1 << ADDR_H_W) > N_HIDDEN) begin : g_hchk
    assign h_ok = w_addr_h < ADDR_H_W'(N_HIDDEN);
  end else begin : g_hall
    assign h_ok = 1'b1;
  end

  if ((1 << ADDR_I_W) > N_IN) begin : g_ichk
    assign i_ok = w_addr_i < ADDR_I_W'(N_IN);
  end else begin : g_iall
    assign i_ok = 1'b1;
  end

  if ((1 << RADDR_W) > WMEM_SIZE) begin : g_rchk
    assign r_ok = raddr < RADDR_W'(WMEM_SIZE);
  end else begin : g_rall
    assign r_ok = 1'b1;
  end

  assign w_flat = RADDR_W'(int'(w_addr_h) * N_IN
                         + int'(w_addr_i));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_en   <= 1'b0;
      wp_addr <= '0;
      wp_data <= '0;
    end else begin
      wp_en   <= w_wr_en & h_ok & i_ok;
      wp_addr <= w_flat;
      wp_data <= w_data;
    end
  end

  sdp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (WMEM_SIZE),
    .ADDR_W (RADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wp_en),
    .waddr (wp_addr),
    .wdata (wp_data),
    .rd_ok (r_ok),
    .raddr (raddr),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_hidden_wmem.sv
// Bench for hidden_wmem: default 4x8 instance plus
// a 3x3 instance for range boundaries.
module tb_hidden_wmem;
  import wmem_pkg::*;

  localparam int SZ = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       w_wr_en = 1'b0;
  logic [1:0] w_addr_h = '0;
  logic [2:0] w_addr_i = '0;
  weight_t    w_data = '0;
  logic [4:0] raddr = '0;
  weight_t    rdata;

  logic       w2_en = 1'b0;
  logic [1:0] w2_h = '0;
  logic [1:0] w2_i = '0;
  weight_t    w2_data = '0;
  logic [3:0] raddr2 = '0;
  weight_t    rdata2;

  int checks = 0;
  int failures = 0;
  weight_t model [SZ];
  weight_t exp_q [$];

  hidden_wmem dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .w_wr_en  (w_wr_en),
    .w_addr_h (w_addr_h),
    .w_addr_i (w_addr_i),
    .w_data   (w_data),
    .raddr    (raddr),
    .rdata    (rdata)
  );

  hidden_wmem #(.N_IN(3), .N_HIDDEN(3)) dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .w_wr_en  (w2_en),
    .w_addr_h (w2_h),
    .w_addr_i (w2_i),
    .w_data   (w2_data),
    .raddr    (raddr2),
    .rdata    (rdata2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int h, input int i,
                    input weight_t d);
    w_wr_en  = 1'b1;
    w_addr_h = h[1:0];
    w_addr_i = i[2:0];
    w_data   = d;
    tick();
    w_wr_en  = 1'b0;
    model[h*8+i] = d;
  endtask

  task automatic test_reset();
    weight_t got;
    weight_t exp;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (rdata !== 16'h0000) begin
      failures++;
      $display("FAIL reset_rdata got=%h exp=0000", rdata);
    end
    checks++;
    if (rdata2 !== 16'h0000) begin
      failures++;
      $display("FAIL reset_rdata2 got=%h exp=0000", rdata2);
    end
    rst_n = 1'b1;
    tick();
`ifdef WMEM_CLEAR_ON_RESET_EN
    for (int a = 0; a < SZ; a++) model[a] = '0;
    for (int a = 0; a < SZ; a++) begin
      exp_q.push_back(16'h0000);
      raddr = a[4:0];
      tick();
      got = rdata;
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL idle_read a=%0d got=%h exp=%h",
                 a, got, exp);
      end
    end
`endif
  endtask

  task automatic test_seq_load();
    weight_t got;
    weight_t exp;
    for (int h = 0; h < 4; h++)
      for (int i = 0; i < 8; i++)
        wr(h, i, weight_t'(h*10 + i + 1));
    tick();
    for (int a = 0; a < SZ; a++) begin
      exp_q.push_back(model[a]);
      raddr = a[4:0];
      tick();
      got = rdata;
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL seq_read a=%0d got=%h exp=%h",
                 a, got, exp);
      end
      if (a == 0 || a == 11 || a == 31) begin
        exp = (a == 0)  ? 16'h0001 :
              (a == 11) ? 16'h000e : 16'h0026;
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL seq_const a=%0d got=%h exp=%h",
                   a, got, exp);
        end
      end
    end
  endtask

  task automatic test_random();
    weight_t got;
    weight_t exp;
    int h;
    int i;
    wr(2, 5, -16'sd500);
    tick();
    raddr = 5'd21;
    tick();
    checks++;
    if (rdata !== 16'hfe0c) begin
      failures++;
      $display("FAIL rand_fixed got=%h exp=fe0c", rdata);
    end
    for (int n = 0; n < 15; n++) begin
      h = int'($urandom_range(0, 3));
      i = int'($urandom_range(0, 7));
      wr(h, i, weight_t'($urandom));
      tick();
      exp_q.push_back(model[h*8+i]);
      raddr = 5'(h*8 + i);
      tick();
      got = rdata;
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL rand_read n=%0d got=%h exp=%h",
                 n, got, exp);
      end
    end
  endtask

  task automatic test_collision();
    weight_t got;
    weight_t exp;
    wr(0, 0, 16'h0001);
    tick();
    w_wr_en  = 1'b1;
    w_addr_h = 2'd0;
    w_addr_i = 3'd0;
    w_data   = 16'h1234;
    tick();
    w_wr_en = 1'b0;
    raddr   = 5'd0;
    exp_q.push_back(model[0]);
    tick();
    got = rdata;
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp || got !== 16'h0001) begin
      failures++;
      $display("FAIL collide_old got=%h exp=0001", got);
    end
    model[0] = 16'h1234;
    exp_q.push_back(model[0]);
    tick();
    got = rdata;
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL collide_new got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_reset_mid_write();
    w_wr_en  = 1'b1;
    w_addr_h = 2'd3;
    w_addr_i = 3'd7;
    w_data   = 16'h7fff;
    raddr    = 5'd31;
    tick();
    w_wr_en = 1'b0;
    rst_n   = 1'b0;
    #1;
    checks++;
    if (rdata !== 16'h0000) begin
      failures++;
      $display("FAIL rst_async got=%h exp=0000", rdata);
    end
    tick();
    tick();
    checks++;
    if (rdata !== 16'h0000) begin
      failures++;
      $display("FAIL rst_hold got=%h exp=0000", rdata);
    end
`ifdef WMEM_CLEAR_ON_RESET_EN
    for (int a = 0; a < SZ; a++) model[a] = '0;
`endif
    rst_n = 1'b1;
    tick();
    exp_q.push_back(model[31]);
    raddr = 5'd31;
    tick();
    checks++;
    if (rdata !== exp_q[0]) begin
      failures++;
      $display("FAIL rst_drop got=%h exp=%h",
               rdata, exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_out_of_range();
    w2_en = 1'b1; w2_h = 2'd1; w2_i = 2'd0;
    w2_data = 16'h5555;
    tick();
    w2_h = 2'd2; w2_i = 2'd2; w2_data = 16'h0777;
    tick();
    w2_h = 2'd0; w2_i = 2'd3; w2_data = 16'haaaa;
    tick();
    w2_en = 1'b0;
    tick();
    tick();
    raddr2 = 4'd3;
    tick();
    checks++;
    if (rdata2 !== 16'h5555) begin
      failures++;
      $display("FAIL oor_write got=%h exp=5555", rdata2);
    end
    raddr2 = 4'd8;
    tick();
    checks++;
    if (rdata2 !== 16'h0777) begin
      failures++;
      $display("FAIL last_entry got=%h exp=0777", rdata2);
    end
    raddr2 = 4'd12;
    tick();
    checks++;
    if (rdata2 !== 16'h0000) begin
      failures++;
      $display("FAIL oor_raddr got=%h exp=0000", rdata2);
    end
  endtask

  initial begin
    test_reset();
    test_seq_load();
    test_random();
    test_collision();
    test_reset_mid_write();
    test_out_of_range();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
